chroma_upsample_buffer: RTL and testbench
=========================================

CHROMA_UPSAMPLE_BUFFER -- requirements
Module: chroma_upsample_buffer

Interface
REQ-001 Parameter Q, default 8: pixel width in bits for all block ports.
REQ-002 Parameter MAX_Y, default 4: Y-block storage depth per MCU; legal values 1, 2 or 4; modes needing more Y blocks than MAX_Y are illegal.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mode  in  2  subsampling mode: 0=4:4:4 (1 Y/MCU), 1=4:2:2 (2 Y/MCU), 2=4:2:0 (4 Y/MCU), 3=reserved.
REQ-006 in_valid  in  1  input block valid.
REQ-007 in_ready  out  1  block accepted when in_valid && in_ready.
REQ-008 in_ch  in  2  0=Y, 1=Cb, 2=Cr, 3=illegal.
REQ-009 in_block  in  [7:0][7:0] x Q  8x8 block, [row][col].
REQ-010 out_valid  out  1  output triplet valid.
REQ-011 out_ready  in  1  triplet consumed when out_valid && out_ready.
REQ-012 y_out, cb_out, cr_out  out  [7:0][7:0] x Q each  co-sited full-resolution blocks.
REQ-013 out_idx  out  2  Y-block index within MCU, raster order.
REQ-014 out_last  out  1  high on final triplet of MCU.
REQ-015 seq_err  out  1  one-cycle pulse on a dropped block.

Function
REQ-016 Block SHALL accept MCUs in the order N Y blocks, one Cb, one Cr; N = 1/2/4 per mode.
REQ-017 Mode SHALL be latched when the first Y of an MCU is accepted; later mode changes within the MCU SHALL be ignored.
REQ-018 FSM states: COL_Y, COL_CB, COL_CR, EMIT; COL_Y -> COL_CB after N-th Y; COL_CB -> COL_CR on Cb; COL_CR -> EMIT on Cr; EMIT -> COL_Y on handshake with out_last=1.
REQ-019 in_ready SHALL be 1 in COL_* states and 0 in EMIT; input and output phases never overlap.
REQ-020 Accepted block with unexpected in_ch, in_ch=3, or mode=3 latched at first Y: block dropped, seq_err=1 next cycle, partial MCU discarded, FSM to COL_Y with Y count 0.
REQ-021 out_valid SHALL assert the cycle after the Cr block is accepted; triplets k=0..N-1 emitted in order, one per handshake.
REQ-022 Outputs SHALL be registered and held stable while out_valid && !out_ready.
REQ-023 4:4:4: cb_out = Cb verbatim (likewise Cr).
REQ-024 4:2:2: cb_out[r][c] = Cb[r][4k + c/2].
REQ-025 4:2:0: with bx=k[0], by=k[1], cb_out[r][c] = Cb[4by + r/2][4bx + c/2]; Y blocks raster: 0=TL, 1=TR, 2=BL, 3=BR.
REQ-026 Nearest-neighbour replication only; no arithmetic, no width change (Q in = Q out).
REQ-027 Next triplet SHALL load in the handshake cycle (back-to-back, one triplet per cycle when out_ready stays 1).
REQ-028 After the final handshake, in_ready SHALL be 1 in the following cycle.

Reset
REQ-029 On rst=0, asynchronously: FSM=COL_Y, Y count 0, latched mode 0, out_valid=0, out_last=0, out_idx=0, seq_err=0, all block outputs 0; in_ready=1 (decoded from COL_Y).
REQ-030 Reset mid-MCU or mid-EMIT SHALL discard all buffered blocks; first block after release is treated as first Y.

Verification
REQ-031 4:4:4, Y=all 0x10, Cb=0x20, Cr=0x30, out_ready=1 -> one triplet, out_idx=0, out_last=1, values verbatim, out_valid one cycle after Cr.
REQ-032 4:2:0, Y blocks k filled with k, Cb[r][c]=8r+c -> 4 triplets; triplet 3 cb_out[0][0]=Cb[4][4]=36, cb_out[7][7]=Cb[7][7]=63; out_last only on idx 3.
REQ-033 4:2:2 with out_ready toggling 1/0 -> 2 triplets, outputs stable during stall, cb_out idx1 [0][0]=Cb[0][4]; in_ready=0 throughout EMIT.
REQ-034 4:2:0, send Y,Y,Cb -> Cb dropped, seq_err one-cycle pulse, next 4 Y+Cb+Cr produce a correct MCU.
REQ-035 Assert rst=0 mid-EMIT after triplet 1 -> out_valid=0 immediately, in_ready=1; fresh 4:4:4 MCU completes normally.
REQ-036 mode changed 2->0 after first Y -> MCU still processed as 4:2:0 (4 triplets).

Source files
------------

// File: rtl/chroma_upsample_buffer.sv
// Collects one MCU of 8x8 blocks (N Y, Cb, Cr) and emits N co-sited full-resolution
// Y/Cb/Cr triplets, replicating chroma samples by nearest neighbour.
module chroma_upsample_buffer #(
    parameter int unsigned Q     = 8,
    parameter int unsigned MAX_Y = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_ch,
    input  logic [7:0][7:0][Q-1:0]  in_block,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0][7:0][Q-1:0]  y_out,
    output logic [7:0][7:0][Q-1:0]  cb_out,
    output logic [7:0][7:0][Q-1:0]  cr_out,
    output logic [1:0]              out_idx,
    output logic                    out_last,
    output logic                    seq_err
);

    localparam int unsigned YW = (MAX_Y > 1) ? $clog2(MAX_Y) : 1;

    typedef logic [7:0][7:0][Q-1:0] blk_t;
    typedef enum logic [1:0] {COL_Y, COL_CB, COL_CR, EMIT} state_e;

    state_e     state_q, state_d;
    logic [2:0] ycnt_q, ycnt_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] k_q, k_d;
    blk_t       ybuf_q [MAX_Y];
    blk_t       ybuf_d [MAX_Y];
    blk_t       cb_q, cb_d, cr_q, cr_d;
    blk_t       y_out_q, y_out_d, cb_out_q, cb_out_d, cr_out_q, cr_out_d;
    logic       out_valid_q, out_valid_d, out_last_q, out_last_d, seq_err_q, seq_err_d;
    logic [1:0] out_idx_q, out_idx_d;

    logic [1:0] eff_mode, load_k;
    logic [2:0] n_eff, n_q;
    logic       mode_bad, accept, load, drop;

    // Y blocks per MCU for a mode; 0 flags the reserved mode
    function automatic logic [2:0] n_of(input logic [1:0] m);
        case (m)
            2'd0:    n_of = 3'd1;
            2'd1:    n_of = 3'd2;
            2'd2:    n_of = 3'd4;
            default: n_of = 3'd0;
        endcase
    endfunction

    // Chroma quadrant/half of Y block k, each sample repeated 2x horizontally (and vertically in 4:2:0)
    function automatic blk_t upsample(input blk_t b, input logic [1:0] k, input logic [1:0] m);
        blk_t       o;
        logic [2:0] sr, sc;
        o = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (m)
                    2'd1: begin
                        sr = 3'(r);
                        sc = {k[0], 2'(c >> 1)};
                    end
                    2'd2: begin
                        sr = {k[1], 2'(r >> 1)};
                        sc = {k[0], 2'(c >> 1)};
                    end
                    default: begin
                        sr = 3'(r);
                        sc = 3'(c);
                    end
                endcase
                o[3'(r)][3'(c)] = b[sr][sc];
            end
        end
        return o;
    endfunction

    always_comb begin
        state_d     = state_q;
        ycnt_d      = ycnt_q;
        mode_d      = mode_q;
        k_d         = k_q;
        ybuf_d      = ybuf_q;
        cb_d        = cb_q;
        cr_d        = cr_q;
        y_out_d     = y_out_q;
        cb_out_d    = cb_out_q;
        cr_out_d    = cr_out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        seq_err_d   = 1'b0;
        load        = 1'b0;
        load_k      = 2'd0;
        drop        = 1'b0;

        // Mode is sampled live only for the first Y of an MCU
        eff_mode = (ycnt_q == 3'd0) ? mode : mode_q;
        n_eff    = n_of(eff_mode);
        mode_bad = (n_eff == 3'd0) || (n_eff > 3'(MAX_Y));
        n_q      = n_of(mode_q);
        accept   = in_valid && (state_q != EMIT);

        case (state_q)
            COL_Y: if (accept) begin
                if ((in_ch != 2'd0) || mode_bad) begin
                    drop = 1'b1;
                end else begin
                    ybuf_d[YW'(ycnt_q)] = in_block;
                    mode_d = eff_mode;
                    ycnt_d = ycnt_q + 3'd1;
                    if (ycnt_q + 3'd1 == n_eff) state_d = COL_CB;
                end
            end
            COL_CB: if (accept) begin
                if (in_ch == 2'd1) begin
                    cb_d    = in_block;
                    state_d = COL_CR;
                end else begin
                    drop = 1'b1;
                end
            end
            COL_CR: if (accept) begin
                if (in_ch == 2'd2) begin
                    cr_d    = in_block;
                    state_d = EMIT;
                    load    = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            default: if (out_ready) begin
                if (out_last_q) begin
                    state_d     = COL_Y;
                    ycnt_d      = 3'd0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else begin
                    load   = 1'b1;
                    load_k = k_q + 2'd1;
                end
            end
        endcase

        // A dropped block discards the partial MCU
        if (drop) begin
            seq_err_d = 1'b1;
            state_d   = COL_Y;
            ycnt_d    = 3'd0;
        end

        if (load) begin
            k_d         = load_k;
            out_valid_d = 1'b1;
            out_idx_d   = load_k;
            out_last_d  = (3'(load_k) + 3'd1 == n_q);
            y_out_d     = ybuf_q[YW'(load_k)];
            cb_out_d    = upsample(cb_q, load_k, mode_q);
            cr_out_d    = upsample(cr_d, load_k, mode_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COL_Y;
            ycnt_q      <= 3'd0;
            mode_q      <= 2'd0;
            k_q         <= 2'd0;
            ybuf_q      <= '{default: '0};
            cb_q        <= '0;
            cr_q        <= '0;
            y_out_q     <= '0;
            cb_out_q    <= '0;
            cr_out_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= 2'd0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ycnt_q      <= ycnt_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            ybuf_q      <= ybuf_d;
            cb_q        <= cb_d;
            cr_q        <= cr_d;
            y_out_q     <= y_out_d;
            cb_out_q    <= cb_out_d;
            cr_out_q    <= cr_out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign in_ready  = (state_q != EMIT);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign seq_err   = seq_err_q;
    assign y_out     = y_out_q;
    assign cb_out    = cb_out_q;
    assign cr_out    = cr_out_q;

endmodule

// File: tb/tb_chroma_upsample_buffer.sv
// Directed bench for chroma_upsample_buffer: each scenario task drives an MCU and checks inline.
module tb_chroma_upsample_buffer;

    typedef logic [7:0][7:0][7:0] blk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_ch;
    blk_t       in_block;
    logic       out_valid;
    logic       out_ready;
    blk_t       y_out, cb_out, cr_out;
    logic [1:0] out_idx;
    logic       out_last;
    logic       seq_err;

    int passed = 0;
    int total  = 0;

    chroma_upsample_buffer #(.Q(8), .MAX_Y(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out), .out_idx(out_idx),
        .out_last(out_last), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic blk_t fill(input logic [7:0] v);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[3'(r)][3'(c)] = v;
        return b;
    endfunction

    function automatic blk_t ramp(input int off);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[3'(r)][3'(c)] = 8'(8 * r + c + off);
        return b;
    endfunction

    // Reference replication written straight from the index formulas
    function automatic blk_t exp_up(input blk_t s, input int k, input int m);
        blk_t o;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                if (m == 0)      o[3'(r)][3'(c)] = s[3'(r)][3'(c)];
                else if (m == 1) o[3'(r)][3'(c)] = s[3'(r)][3'(4 * k + c / 2)];
                else             o[3'(r)][3'(c)] = s[3'(4 * (k / 2) + r / 2)][3'(4 * (k % 2) + c / 2)];
            end
        return o;
    endfunction

    // One block per cycle; caller guarantees the DUT is collecting
    task automatic send(input logic [1:0] ch, input blk_t b, input logic [1:0] md);
        in_valid = 1'b1;
        in_ch    = ch;
        in_block = b;
        mode     = md;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if (in_ready !== 1'b1)  $display("FAIL rst_in_ready got=%b exp=1", in_ready);   else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_last !== 1'b0)  $display("FAIL rst_out_last got=%b exp=0", out_last);   else passed++;
        total++; if (out_idx !== 2'd0)   $display("FAIL rst_out_idx got=%0d exp=0", out_idx);    else passed++;
        total++; if (seq_err !== 1'b0)   $display("FAIL rst_seq_err got=%b exp=0", seq_err);     else passed++;
        total++; if ({y_out, cb_out, cr_out} !== '0) $display("FAIL rst_blocks got nonzero exp=0"); else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_444;
        out_ready = 1'b1;
        send(2'd0, fill(8'h10), 2'd0);
        send(2'd1, fill(8'h20), 2'd0);
        send(2'd2, fill(8'h30), 2'd0);
        total++; if (out_valid !== 1'b1) $display("FAIL s444_valid got=%b exp=1", out_valid); else passed++;
        total++; if (out_idx !== 2'd0)   $display("FAIL s444_idx got=%0d exp=0", out_idx);    else passed++;
        total++; if (out_last !== 1'b1)  $display("FAIL s444_last got=%b exp=1", out_last);   else passed++;
        total++; if (in_ready !== 1'b0)  $display("FAIL s444_in_ready got=%b exp=0", in_ready); else passed++;
        total++; if (y_out !== fill(8'h10))  $display("FAIL s444_y got=%h exp=%h", y_out, fill(8'h10));   else passed++;
        total++; if (cb_out !== fill(8'h20)) $display("FAIL s444_cb got=%h exp=%h", cb_out, fill(8'h20)); else passed++;
        total++; if (cr_out !== fill(8'h30)) $display("FAIL s444_cr got=%h exp=%h", cr_out, fill(8'h30)); else passed++;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL s444_done_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1)  $display("FAIL s444_done_ready got=%b exp=1", in_ready);  else passed++;
    endtask

    task automatic test_420;
        blk_t cb, cr;
        cb = ramp(0);
        cr = ramp(100);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(2'd0, fill(8'(k)), 2'd2);
        send(2'd1, cb, 2'd2);
        send(2'd2, cr, 2'd2);
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1) $display("FAIL s420_valid%0d got=%b exp=1", k, out_valid); else passed++;
            total++; if (out_idx !== 2'(k))  $display("FAIL s420_idx%0d got=%0d exp=%0d", k, out_idx, k); else passed++;
            total++; if (out_last !== (k == 3)) $display("FAIL s420_last%0d got=%b exp=%b", k, out_last, k == 3); else passed++;
            total++; if (in_ready !== 1'b0)  $display("FAIL s420_in_ready%0d got=%b exp=0", k, in_ready); else passed++;
            total++; if (y_out !== fill(8'(k))) $display("FAIL s420_y%0d got=%h exp=%h", k, y_out, fill(8'(k))); else passed++;
            total++; if (cb_out !== exp_up(cb, k, 2)) $display("FAIL s420_cb%0d got=%h exp=%h", k, cb_out, exp_up(cb, k, 2)); else passed++;
            total++; if (cr_out !== exp_up(cr, k, 2)) $display("FAIL s420_cr%0d got=%h exp=%h", k, cr_out, exp_up(cr, k, 2)); else passed++;
            if (k == 3) begin
                total++; if (cb_out[0][0] !== 8'd36) $display("FAIL s420_cb00 got=%0d exp=36", cb_out[0][0]); else passed++;
                total++; if (cb_out[7][7] !== 8'd63) $display("FAIL s420_cb77 got=%0d exp=63", cb_out[7][7]); else passed++;
            end
            @(posedge clk);
            #1;
        end
        total++; if (out_valid !== 1'b0) $display("FAIL s420_done_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1)  $display("FAIL s420_done_ready got=%b exp=1", in_ready);  else passed++;
    endtask

    task automatic test_422_stall;
        blk_t cb, cr, y_s, cb_s, cr_s;
        cb = ramp(0);
        cr = ramp(100);
        out_ready = 1'b0;
        send(2'd0, fill(8'd1), 2'd1);
        send(2'd0, fill(8'd2), 2'd1);
        send(2'd1, cb, 2'd1);
        send(2'd2, cr, 2'd1);
        total++; if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_last !== 1'b0)
            $display("FAIL s422_t0 got=%b/%0d/%b exp=1/0/0", out_valid, out_idx, out_last); else passed++;
        total++; if (cb_out !== exp_up(cb, 0, 1)) $display("FAIL s422_cb0 got=%h exp=%h", cb_out, exp_up(cb, 0, 1)); else passed++;
        y_s = y_out; cb_s = cb_out; cr_s = cr_out;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || out_idx !== 2'd0) $display("FAIL s422_stall_ctl got=%b/%0d exp=1/0", out_valid, out_idx); else passed++;
        total++; if ({y_out, cb_out, cr_out} !== {y_s, cb_s, cr_s}) $display("FAIL s422_stall_data got=%h exp=%h", cb_out, cb_s); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL s422_stall_ready got=%b exp=0", in_ready); else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (out_idx !== 2'd1 || out_last !== 1'b1) $display("FAIL s422_t1 got=%0d/%b exp=1/1", out_idx, out_last); else passed++;
        total++; if (cb_out[0][0] !== 8'd4) $display("FAIL s422_cb00 got=%0d exp=4", cb_out[0][0]); else passed++;
        total++; if (y_out !== fill(8'd2)) $display("FAIL s422_y1 got=%h exp=%h", y_out, fill(8'd2)); else passed++;
        total++; if (cr_out !== exp_up(cr, 1, 1)) $display("FAIL s422_cr1 got=%h exp=%h", cr_out, exp_up(cr, 1, 1)); else passed++;
        cb_s = cb_out;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b1 || cb_out !== cb_s) $display("FAIL s422_stall1 got=%b exp=1", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL s422_stall1_ready got=%b exp=0", in_ready); else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL s422_done got=%b/%b exp=0/1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_seq_err;
        blk_t cb, cr;
        cb = ramp(0);
        cr = ramp(100);
        out_ready = 1'b1;
        send(2'd0, fill(8'h01), 2'd2);
        send(2'd0, fill(8'h02), 2'd2);
        send(2'd1, cb, 2'd2);
        total++; if (seq_err !== 1'b1)   $display("FAIL serr_pulse got=%b exp=1", seq_err);   else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL serr_valid got=%b exp=0", out_valid); else passed++;
        @(posedge clk);
        #1;
        total++; if (seq_err !== 1'b0) $display("FAIL serr_clear got=%b exp=0", seq_err); else passed++;
        for (int k = 0; k < 4; k++) send(2'd0, fill(8'(8'h40 + k)), 2'd2);
        send(2'd1, cb, 2'd2);
        send(2'd2, cr, 2'd2);
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_last !== (k == 3))
                $display("FAIL serr_ctl%0d got=%b/%0d/%b", k, out_valid, out_idx, out_last); else passed++;
            total++; if (y_out !== fill(8'(8'h40 + k))) $display("FAIL serr_y%0d got=%h exp=%h", k, y_out, fill(8'(8'h40 + k))); else passed++;
            total++; if (cb_out !== exp_up(cb, k, 2)) $display("FAIL serr_cb%0d got=%h exp=%h", k, cb_out, exp_up(cb, k, 2)); else passed++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mode_change;
        blk_t cb;
        cb = ramp(0);
        out_ready = 1'b1;
        send(2'd0, fill(8'h50), 2'd2);
        for (int k = 1; k < 4; k++) send(2'd0, fill(8'(8'h50 + k)), 2'd0);
        send(2'd1, cb, 2'd0);
        send(2'd2, fill(8'h99), 2'd0);
        for (int k = 0; k < 4; k++) begin
            total++; if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_last !== (k == 3))
                $display("FAIL mchg_ctl%0d got=%b/%0d/%b", k, out_valid, out_idx, out_last); else passed++;
            total++; if (cb_out !== exp_up(cb, k, 2)) $display("FAIL mchg_cb%0d got=%h exp=%h", k, cb_out, exp_up(cb, k, 2)); else passed++;
            @(posedge clk);
            #1;
        end
        total++; if (out_valid !== 1'b0) $display("FAIL mchg_done got=%b exp=0", out_valid); else passed++;
    endtask

    task automatic test_illegal;
        send(2'd3, fill(8'h11), 2'd0);
        total++; if (seq_err !== 1'b1) $display("FAIL ill_ch3 got=%b exp=1", seq_err); else passed++;
        send(2'd0, fill(8'h11), 2'd3);
        total++; if (seq_err !== 1'b1) $display("FAIL ill_mode3 got=%b exp=1", seq_err); else passed++;
        @(posedge clk);
        #1;
        total++; if (seq_err !== 1'b0 || in_ready !== 1'b1) $display("FAIL ill_recover got=%b/%b exp=0/1", seq_err, in_ready); else passed++;
    endtask

    task automatic test_reset_mid_emit;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(2'd0, fill(8'(k + 1)), 2'd2);
        send(2'd1, ramp(0), 2'd2);
        send(2'd2, ramp(3), 2'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (out_idx !== 2'd1 || out_valid !== 1'b1) $display("FAIL rme_pre got=%0d/%b exp=1/1", out_idx, out_valid); else passed++;
        rst = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL rme_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1)  $display("FAIL rme_ready got=%b exp=1", in_ready);  else passed++;
        total++; if (out_idx !== 2'd0 || y_out !== '0) $display("FAIL rme_clear got=%0d exp=0", out_idx); else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'd0, fill(8'hA1), 2'd0);
        send(2'd1, fill(8'hB2), 2'd0);
        send(2'd2, fill(8'hC3), 2'd0);
        total++; if (out_valid !== 1'b1 || out_last !== 1'b1 || out_idx !== 2'd0)
            $display("FAIL rme_fresh_ctl got=%b/%b/%0d exp=1/1/0", out_valid, out_last, out_idx); else passed++;
        total++; if ({y_out, cb_out, cr_out} !== {fill(8'hA1), fill(8'hB2), fill(8'hC3)})
            $display("FAIL rme_fresh_data got=%h exp=%h", y_out, fill(8'hA1)); else passed++;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rme_fresh_done got=%b/%b exp=0/1", out_valid, in_ready); else passed++;
    endtask

    initial begin
        rst       = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_ch     = 2'd0;
        in_block  = '0;
        out_ready = 1'b0;
        test_reset();
        test_444();
        test_420();
        test_422_stall();
        test_seq_err();
        test_mode_change();
        test_illegal();
        test_reset_mid_emit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
